// File: rtl/decomp_cascade_logic_pkg.sv
// Shared types and constants for the decompression cascade glue logic.
// The FSM encoding, the default timing and the byte-mask helpers live here.
package decomp_cascade_logic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]  WAIT_TIME_DEFAULT  = 4'hA;
  localparam int          SKID_DEPTH_DEFAULT = 2;
  localparam logic [1:0]  FULL_WORD          = 2'b00;
  localparam logic [16:0] MAX_LEN            = 17'h1_FFFF;

  typedef struct packed {
    logic        last;
    logic [1:0]  mask;
    logic [31:0] data;
  } skid_entry_t;

  // lmask 3'b000 cannot describe a real word, so it is read as a full word.
  function automatic logic [1:0] lmask_to_bytemask(input logic [2:0] lmask);
    if (lmask[2] || (lmask[1:0] == 2'b00)) begin
      return FULL_WORD;
    end
    return lmask[1:0];
  endfunction

  function automatic logic [2:0] bytemask_bytes(input logic [1:0] mask);
    if (mask == FULL_WORD) begin
      return 3'd4;
    end
    return {1'b0, mask};
  endfunction

endpackage

// File: rtl/decomp_cascade_logic_if.sv
// Huffman-output / LZ4-input handshake bundle.
// master = stream source/sink environment, slave = the cascade glue block.
interface decomp_cascade_logic_if;

  logic [31:0] huff_data;
  logic        huff_valid;
  logic        huff_last;
  logic [2:0]  huff_lmask;
  logic        huff_empty;
  logic        huff_done;
  logic        huff_oen;

  logic        lz4_full;
  logic [33:0] lz4_data;
  logic        lz4_valid;
  logic        lz4_blk_end;
  logic        lz4_in_end;
  logic        len_err;

  modport master (
    output huff_data,
    output huff_valid,
    output huff_last,
    output huff_lmask,
    output huff_empty,
    output huff_done,
    input  huff_oen,
    output lz4_full,
    input  lz4_data,
    input  lz4_valid,
    input  lz4_blk_end,
    input  lz4_in_end,
    input  len_err
  );

  modport slave (
    input  huff_data,
    input  huff_valid,
    input  huff_last,
    input  huff_lmask,
    input  huff_empty,
    input  huff_done,
    output huff_oen,
    input  lz4_full,
    output lz4_data,
    output lz4_valid,
    output lz4_blk_end,
    output lz4_in_end,
    output len_err
  );

endinterface

// File: rtl/decomp_skid_buf.sv
// Small skid FIFO holding words that arrive while the LZ4 input FIFO is full.
// Push and pop may happen in the same cycle; flush empties it at stream start.
module decomp_skid_buf
  import decomp_cascade_logic_pkg::*;
#(
  parameter int DEPTH = SKID_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  skid_entry_t                  push_entry,
  input  logic                         pop,
  output skid_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  skid_entry_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == PW'(gi))) begin
        mem[gi] <= push_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally so the oldest word can go out the same cycle.
  assign head      = mem[rd_ptr_reg];
  assign occupancy = count_reg;

endmodule

// File: rtl/decomp_cascade_logic.sv
// Re-packs Huffman decoder words into LZ4 decoder input words, tracks block
// byte counts and raises end-of-stream. Optional length check: BLK_LEN_CHECK_EN.
module decomp_cascade_logic
  import decomp_cascade_logic_pkg::*;
#(
  parameter logic [3:0] WAIT_TIME  = WAIT_TIME_DEFAULT,
  parameter int         SKID_DEPTH = SKID_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_decompress,
  input  logic [16:0]            max_stat_len,
  input  logic                   max_stat_valid,
  decomp_cascade_logic_if.slave  bus
);

  localparam int SCW = $clog2(SKID_DEPTH + 1);

  state_t        state_reg;
  logic          huff_oen_reg;
  logic [33:0]   lz4_data_reg;
  logic          lz4_valid_reg;
  logic          blk_end_reg;
  logic          in_end_reg;
  logic [16:0]   blk_cnt_reg;
  logic [16:0]   max_stat_len_reg;
  logic [3:0]    wait_count_reg;

  skid_entry_t   in_entry;
  skid_entry_t   skid_head;
  skid_entry_t   out_entry;
  logic [SCW-1:0] skid_cnt;
  logic          skid_nonempty;
  logic          skid_push;
  logic          skid_pop;
  logic          write_en;
  logic [2:0]    word_bytes;
  logic [17:0]   blk_sum;
  logic          oen_next;
  logic          drained;

  assign in_entry = '{last: bus.huff_last,
                      mask: lmask_to_bytemask(bus.huff_lmask),
                      data: bus.huff_data};

  assign skid_nonempty = (skid_cnt != '0);

  // Older skid content always leaves before a word arriving this cycle.
  assign out_entry = skid_nonempty ? skid_head : in_entry;
  assign write_en  = !bus.lz4_full && (skid_nonempty || bus.huff_valid);
  assign skid_push = bus.huff_valid && (bus.lz4_full || skid_nonempty);
  assign skid_pop  = !bus.lz4_full && skid_nonempty;

  assign word_bytes = bytemask_bytes(out_entry.mask);
  assign blk_sum    = {1'b0, blk_cnt_reg} + {15'b0, word_bytes};

  assign oen_next = ((state_reg == RUN) || (state_reg == DRAIN)) &&
                    !bus.huff_empty && !bus.lz4_full &&
                    !skid_nonempty && !max_stat_valid;

  // A word requested last cycle is on huff_valid now; both must be idle.
  assign drained = (wait_count_reg == WAIT_TIME) && bus.huff_empty &&
                   !skid_nonempty && !huff_oen_reg && !bus.huff_valid;

  decomp_skid_buf #(
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (start_decompress),
    .push       (skid_push),
    .push_entry (in_entry),
    .pop        (skid_pop),
    .head       (skid_head),
    .occupancy  (skid_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      in_end_reg <= 1'b0;
    end else if (start_decompress) begin
      state_reg  <= RUN;
      in_end_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE:  state_reg <= IDLE;
        RUN: begin
          if (bus.huff_done) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state_reg  <= DONE;
            in_end_reg <= 1'b1;
          end
        end
        DONE:    state_reg <= DONE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      huff_oen_reg  <= 1'b0;
      lz4_data_reg  <= '0;
      lz4_valid_reg <= 1'b0;
      blk_end_reg   <= 1'b0;
    end else begin
      huff_oen_reg  <= oen_next;
      lz4_valid_reg <= write_en;
      blk_end_reg   <= write_en && out_entry.last;
      if (write_en) begin
        lz4_data_reg <= {out_entry.mask, out_entry.data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_reg      <= '0;
      max_stat_len_reg <= MAX_LEN;
      wait_count_reg   <= '0;
    end else begin
      if (start_decompress || max_stat_valid) begin
        blk_cnt_reg <= '0;
      end else if (write_en) begin
        if (out_entry.last) begin
          blk_cnt_reg <= '0;
        end else if (blk_sum > {1'b0, MAX_LEN}) begin
          blk_cnt_reg <= MAX_LEN;
        end else begin
          blk_cnt_reg <= blk_sum[16:0];
        end
      end

      if (max_stat_valid) begin
        max_stat_len_reg <= max_stat_len;
      end

      if (start_decompress) begin
        wait_count_reg <= '0;
      end else if (bus.huff_done && (wait_count_reg != WAIT_TIME)) begin
        wait_count_reg <= wait_count_reg + 4'd1;
      end
    end
  end

`ifdef BLK_LEN_CHECK_EN
  logic len_err_reg;
  logic len_mismatch;

  // A short final block is legal once the Huffman decoder has finished.
  assign len_mismatch = (blk_sum != {1'b0, max_stat_len_reg}) &&
                        !((blk_sum < {1'b0, max_stat_len_reg}) && bus.huff_done);

  always_ff @(posedge clk) begin
    if (rst || start_decompress) begin
      len_err_reg <= 1'b0;
    end else if (write_en && out_entry.last && len_mismatch) begin
      len_err_reg <= 1'b1;
    end
  end

  assign bus.len_err = len_err_reg;
`else
  logic unused_max_len;
  assign unused_max_len = ^max_stat_len_reg;
  assign bus.len_err    = 1'b0;
`endif

  assign bus.huff_oen    = huff_oen_reg;
  assign bus.lz4_data    = lz4_data_reg;
  assign bus.lz4_valid   = lz4_valid_reg;
  assign bus.lz4_blk_end = blk_end_reg;
  assign bus.lz4_in_end  = in_end_reg;

endmodule

// File: tb/tb_decomp_cascade_logic.sv
// Directed + randomized bench for decomp_cascade_logic: a Huffman FIFO model
// feeds the block and a scoreboard predicts the LZ4-side word stream.
module tb_decomp_cascade_logic;
  import decomp_cascade_logic_pkg::*;

`ifdef BLK_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_decompress;
  logic [16:0] max_stat_len;
  logic        max_stat_valid;

  decomp_cascade_logic_if bus();

  decomp_cascade_logic dut (
    .clk              (clk),
    .rst              (rst),
    .start_decompress (start_decompress),
    .max_stat_len     (max_stat_len),
    .max_stat_valid   (max_stat_valid),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  lmask;
  } hword_t;

  typedef struct {
    logic [33:0] data;
    logic        last;
  } exp_t;

  hword_t hq[$];
  exp_t   expq[$];
  hword_t cur_w;
  exp_t   cur_e;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          wr_count     = 0;
  int          blkend_count = 0;
  logic        lat_chk      = 1'b0;
  logic        prev_hv      = 1'b0;
  logic [16:0] model_max    = 17'h1_FFFF;
  int          blk_bytes    = 0;
  logic        model_err    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected output word derived from the input word by byte-count arithmetic.
  task automatic push_word(input logic [31:0] d, input logic last, input logic [2:0] lm);
    hword_t w;
    exp_t   e;
    int     nb;
    w.data = d; w.last = last; w.lmask = lm;
    hq.push_back(w);
    nb = (lm >= 3'd4 || lm == 3'd0) ? 4 : int'(lm);
    e.data = {((nb == 4) ? 2'b00 : 2'(nb)), d};
    e.last = last;
    expq.push_back(e);
    blk_bytes += nb;
    if (last) begin
      if (blk_bytes != int'(model_max)) model_err = 1'b1;
      blk_bytes = 0;
    end
  endtask

  task automatic do_start();
    start_decompress = 1'b1;
    tick(1);
    start_decompress = 1'b0;
    model_err = 1'b0;
    blk_bytes = 0;
  endtask

  task automatic load_max(input logic [16:0] len);
    max_stat_len   = len;
    max_stat_valid = 1'b1;
    tick(1);
    max_stat_valid = 1'b0;
    model_max = len;
    blk_bytes = 0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((hq.size() != 0 || expq.size() != 0) && c < budget) begin
      tick(1);
      c++;
    end
    tick(2);
    check({tag, "_drained"}, 64'(expq.size()), 0);
  endtask

  task automatic wait_stream(input string tag);
    int   c;
    logic seen;
    c = 0; seen = 1'b0;
    while (!seen && c < 30) begin
      tick(1);
      c++;
      seen = bus.huff_valid && bus.huff_oen;
    end
    check({tag, "_stream"}, 64'(seen), 1);
  endtask

  // Huffman output FIFO model: registered read enable, data one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      hq.delete();
      bus.huff_valid <= 1'b0;
      bus.huff_empty <= 1'b1;
      bus.huff_data  <= '0;
      bus.huff_last  <= 1'b0;
      bus.huff_lmask <= 3'b100;
    end else begin
      if (bus.huff_oen && hq.size() > 0) begin
        cur_w = hq.pop_front();
        bus.huff_valid <= 1'b1;
        bus.huff_data  <= cur_w.data;
        bus.huff_last  <= cur_w.last;
        bus.huff_lmask <= cur_w.lmask;
      end else begin
        bus.huff_valid <= 1'b0;
      end
      bus.huff_empty <= (hq.size() == 0);
    end
  end

  // Output monitor, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (bus.lz4_valid) begin
        check("write_expected", 64'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          cur_e = expq.pop_front();
          check("lz4_data", 64'(bus.lz4_data), 64'(cur_e.data));
          check("lz4_blk_end", 64'(bus.lz4_blk_end), 64'(cur_e.last));
        end
        check("valid_while_full", 64'(bus.lz4_full), 0);
        if (lat_chk) check("latency", 64'(prev_hv), 1);
        wr_count++;
      end else begin
        check("blk_end_idle", 64'(bus.lz4_blk_end), 0);
      end
      if (bus.lz4_full) check("oen_during_full", 64'(bus.huff_oen), 0);
      if (bus.lz4_blk_end) blkend_count++;
    end
    prev_hv = bus.huff_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int bend;
    int cyc;
    rst = 1'b1; start_decompress = 1'b0; max_stat_len = '0; max_stat_valid = 1'b0;
    bus.huff_done = 1'b0; bus.lz4_full = 1'b0;
    tick(3);
    check("rst_lz4_valid", 64'(bus.lz4_valid), 0);
    check("rst_huff_oen", 64'(bus.huff_oen), 0);
    check("rst_lz4_data", 64'(bus.lz4_data), 0);
    check("rst_blk_end", 64'(bus.lz4_blk_end), 0);
    check("rst_in_end", 64'(bus.lz4_in_end), 0);
    check("rst_len_err", 64'(bus.len_err), 0);
    check("rst_state", 64'(dut.state_reg), 0);
    check("rst_max_len", 64'(dut.max_stat_len_reg), 64'h1_FFFF);
    check("rst_skid", 64'(dut.skid_cnt), 0);
    rst = 1'b0;
    tick(1);

    // 8 full words, free-flowing output
    do_start();
    load_max(17'd32);
    base = wr_count; bend = blkend_count;
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) push_word($urandom, (i == 7), 3'b100);
    wait_drain("t1", 100);
    lat_chk = 1'b0;
    check("t1_writes", 64'(wr_count - base), 8);
    check("t1_blk_ends", 64'(blkend_count - bend), 1);
    check("t1_blk_cnt", 64'(dut.blk_cnt_reg), 0);

    // back-pressure with two words in flight
    load_max(17'd24);
    base = wr_count;
    for (int i = 0; i < 6; i++) push_word($urandom, (i == 5), 3'b100);
    wait_stream("t2");
    bus.lz4_full = 1'b1;
    tick(2);
    check("t2_skid_cnt", 64'(dut.skid_cnt), 2);
    tick(3);
    bus.lz4_full = 1'b0;
    wait_drain("t2", 100);
    check("t2_writes", 64'(wr_count - base), 6);

    // partial last word
    load_max(17'd15);
    bend = blkend_count;
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 3'b100);
    push_word($urandom, 1'b1, 3'b011);
    wait_drain("t3", 100);
    check("t3_blk_ends", 64'(blkend_count - bend), 1);
    check("t3_blk_cnt", 64'(dut.blk_cnt_reg), 0);

    // block length check: 5 words vs 16 bytes, then 4 words
    do_start();
    load_max(17'd16);
    for (int i = 0; i < 5; i++) push_word($urandom, (i == 4), 3'b100);
    wait_drain("t4a", 100);
    check("t4_len_err_long", 64'(bus.len_err), 64'(LEN_CHK));
    do_start();
    check("t4_len_err_clear", 64'(bus.len_err), 0);
    load_max(17'd16);
    for (int i = 0; i < 4; i++) push_word($urandom, (i == 3), 3'b100);
    wait_drain("t4b", 100);
    check("t4_len_err_exact", 64'(bus.len_err), 0);

    // randomized words, masks and back-pressure
    do_start();
    load_max(17'd64);
    base = wr_count;
    for (int i = 0; i < 40; i++)
      push_word($urandom, ($urandom_range(0, 3) == 0) || (i == 39), 3'($urandom_range(0, 7)));
    for (int c = 0; c < 400 && (hq.size() != 0 || expq.size() != 0); c++) begin
      bus.lz4_full = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    bus.lz4_full = 1'b0;
    wait_drain("rnd", 100);
    check("rnd_writes", 64'(wr_count - base), 40);
    check("rnd_len_err", 64'(bus.len_err), 64'(LEN_CHK && model_err));

    // end-of-stream after huff_done and a 3-word drain
    do_start();
    load_max(17'd12);
    base = wr_count;
    for (int i = 0; i < 3; i++) push_word($urandom, (i == 2), 3'b100);
    bus.huff_done = 1'b1;
    cyc = 0;
    while (!bus.lz4_in_end && cyc < 40) begin
      tick(1);
      cyc++;
    end
    check("t5_in_end", 64'(bus.lz4_in_end), 1);
    check("t5_writes_before_end", 64'(wr_count - base), 3);
    check("t5_min_wait", 64'(cyc >= 10), 1);
    bus.huff_done = 1'b0;
    tick(5);
    check("t5_in_end_sticky", 64'(bus.lz4_in_end), 1);
    check("t5_state_done", 64'(dut.state_reg), 3);
    do_start();
    check("t5_in_end_cleared", 64'(bus.lz4_in_end), 0);

    // reset during DRAIN with a full skid buffer
    load_max(17'd24);
    for (int i = 0; i < 6; i++) push_word($urandom, (i == 5), 3'b100);
    wait_stream("t6");
    bus.lz4_full  = 1'b1;
    bus.huff_done = 1'b1;
    tick(3);
    check("t6_state_drain", 64'(dut.state_reg), 2);
    check("t6_skid_full", 64'(dut.skid_cnt), 2);
    rst = 1'b1;
    expq.delete();
    tick(1);
    check("t6_rst_valid", 64'(bus.lz4_valid), 0);
    check("t6_rst_oen", 64'(bus.huff_oen), 0);
    check("t6_rst_data", 64'(bus.lz4_data), 0);
    check("t6_rst_in_end", 64'(bus.lz4_in_end), 0);
    check("t6_rst_state", 64'(dut.state_reg), 0);
    check("t6_rst_skid", 64'(dut.skid_cnt), 0);
    rst = 1'b0;
    bus.lz4_full  = 1'b0;
    bus.huff_done = 1'b0;
    tick(2);
    do_start();
    load_max(17'd16);
    base = wr_count; bend = blkend_count;
    for (int i = 0; i < 4; i++) push_word($urandom, (i == 3), 3'b100);
    wait_drain("t6", 100);
    check("t6_clean_writes", 64'(wr_count - base), 4);
    check("t6_clean_blk_ends", 64'(blkend_count - bend), 1);
    check("t6_len_err", 64'(bus.len_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
